// File: rtl/sasc_pkg.sv
// ---------------------------------------------------------------------------
// sasc_pkg
//  Shared definitions for the sasc serial receiver.
//  - rx_state_e   : receiver FSM states (IDLE / START / DATA / STOP)
//  - SAMPLE_PHASE : tick phase within a bit at which rxd is sampled (mid-bit)
//  - LAST_PHASE   : tick phase at which the FSM advances to the next bit
// ---------------------------------------------------------------------------
package sasc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam logic [1:0] SAMPLE_PHASE = 2'd2;
    localparam logic [1:0] LAST_PHASE   = 2'd3;

endpackage

// File: rtl/sasc_rx_fifo.sv
// ---------------------------------------------------------------------------
// sasc_rx_fifo
//  First-word-fall-through receive FIFO, DATA_BITS wide, 2**FIFO_AW deep.
//  Pointers carry one extra wrap bit so full/empty come from an MSB compare.
//  Ports:
//   clk, rst   : clock, synchronous active-high reset (flushes and zeroes)
//   push       : write push_data this cycle (dropped when full without pop)
//   push_data  : character to write
//   pop        : consume the head entry (ignored when empty)
//   rd_data    : head entry, mem[rd_ptr]
//   full/empty : occupancy flags
// ---------------------------------------------------------------------------
module sasc_rx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int FIFO_AW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 full,
    output logic                 empty
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [DATA_BITS-1:0] mem_d [DEPTH];
    logic [FIFO_AW:0]     wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]     rd_ptr_q, rd_ptr_d;
    logic                 do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    // A push into a full FIFO is only accepted when the head leaves in the
    // same cycle; the write then lands in the slot being vacated.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[FIFO_AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/sasc_rx.sv
// ---------------------------------------------------------------------------
// sasc_rx
//  Serial receiver: oversamples rxd at 4x baud (sio_ce_x4), deframes 8N1
//  characters LSB-first and buffers them in a small FWFT FIFO.
//  Ports:
//   clk, rst     : clock, synchronous active-high reset
//   sio_ce_x4    : one-cycle enable at 4x baud; all bit timing advances on it
//   rxd          : asynchronous serial line, idle high
//   rx_data      : FIFO head, meaningful while rx_valid = 1
//   rx_valid     : FIFO not empty
//   rx_ready     : consumer accepts; pop on rx_valid & rx_ready
//   framing_err  : one-cycle pulse, stop bit sampled low
//   overrun      : one-cycle pulse, good character dropped on a full FIFO
//   rx_busy      : receiver FSM is not idle
// ---------------------------------------------------------------------------
module sasc_rx
    import sasc_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int FIFO_AW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sio_ce_x4,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 framing_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic                 rxd_meta_q, rxd_meta_d;
    logic                 rxd_s_q, rxd_s_d;
    logic [1:0]           sync_fill_q, sync_fill_d;
    logic                 armed_q, armed_d;
    logic [1:0]           phase_q, phase_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 framing_err_q, framing_err_d;
    logic                 overrun_q, overrun_d;

    logic push, pop, fifo_full, fifo_empty;

    assign rx_valid    = ~fifo_empty;
    assign pop         = rx_valid & rx_ready;
    assign rx_busy     = (state_q != ST_IDLE);
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;

    // Next-state logic. The synchronizer runs every clock; the FSM, phase and
    // bit counters move only on sio_ce_x4 ticks. sync_fill marks when both
    // synchronizer stages hold real line samples rather than reset values, so
    // a line held low through reset never arms the start detector.
    always_comb begin
        state_d       = state_q;
        rxd_meta_d    = rxd;
        rxd_s_d       = rxd_meta_q;
        sync_fill_d   = {sync_fill_q[0], 1'b1};
        armed_d       = armed_q;
        phase_d       = phase_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        framing_err_d = 1'b0;
        push          = 1'b0;

        if ((state_q == ST_IDLE) && rxd_s_q && sync_fill_q[1]) begin
            armed_d = 1'b1;
        end

        if (sio_ce_x4) begin
            case (state_q)
                ST_IDLE: begin
                    if (armed_q && !rxd_s_q) begin
                        state_d = ST_START;
                        phase_d = 2'd1;
                    end
                end
                ST_START: begin
                    phase_d = phase_q + 2'd1;
                    if ((phase_q == SAMPLE_PHASE) && rxd_s_q) begin
                        state_d = ST_IDLE;
                    end else if (phase_q == LAST_PHASE) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == SAMPLE_PHASE) begin
                        shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
                    end
                    if (phase_q == LAST_PHASE) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    phase_d = phase_q + 2'd1;
                    // Leave at the stop mid-bit so the next start edge is
                    // caught as early as possible.
                    if (phase_q == SAMPLE_PHASE) begin
                        state_d = ST_IDLE;
                        if (rxd_s_q) begin
                            push = 1'b1;
                        end else begin
                            framing_err_d = 1'b1;
                            armed_d       = 1'b0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        overrun_d = push & fifo_full & ~pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rxd_meta_q    <= 1'b1;
            rxd_s_q       <= 1'b1;
            sync_fill_q   <= 2'b00;
            armed_q       <= 1'b0;
            phase_q       <= 2'd0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rxd_meta_q    <= rxd_meta_d;
            rxd_s_q       <= rxd_s_d;
            sync_fill_q   <= sync_fill_d;
            armed_q       <= armed_d;
            phase_q       <= phase_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    sasc_rx_fifo #(
        .DATA_BITS(DATA_BITS),
        .FIFO_AW  (FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(shift_q),
        .pop      (pop),
        .rd_data  (rx_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_sasc_rx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_sasc_rx
//  Drives 8N1 frames into sasc_rx on a 4x-baud enable (one tick every 26
//  clocks) and checks the receiver against a queue model of the FIFO plus
//  expected counts of framing-error and overrun pulses.
// ---------------------------------------------------------------------------
module tb_sasc_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sio_ce_x4 = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_err;
    logic       overrun;
    logic       rx_busy;

    int         errors = 0;
    int         checks = 0;
    int         ce_cnt = 0;
    bit         mon_en = 1'b0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         exp_fe = 0;
    int         exp_ov = 0;
    logic [7:0] model_q [$];

    sasc_rx dut (
        .clk        (clk),
        .rst        (rst),
        .sio_ce_x4  (sio_ce_x4),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .framing_err(framing_err),
        .overrun    (overrun),
        .rx_busy    (rx_busy)
    );

    // 100 MHz clock and a free-running 4x-baud enable, high one clock in 26.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ce_cnt == 25) begin
            ce_cnt    <= 0;
            sio_ce_x4 <= 1'b1;
        end else begin
            ce_cnt    <= ce_cnt + 1;
            sio_ce_x4 <= 1'b0;
        end
    end

    // Compares one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Monitor on the falling edge: counts error pulse cycles and checks every
    // pop against the head of the model queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (framing_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (framing_err || overrun) begin
                checkOutput("err_exclusive", 32'(framing_err & overrun), 32'd0);
            end
            if (rx_valid && rx_ready) begin
                if (model_q.size() == 0) begin
                    checkOutput("pop_when_model_empty", 32'(rx_valid), 32'd0);
                end else begin
                    checkOutput("pop_data", 32'(rx_data), 32'(model_q.pop_front()));
                end
            end
        end
    end

    // Consumes one enable tick and leaves the bench 1 ns after that edge.
    task automatic wait_tick();
        do @(negedge clk); while (sio_ce_x4 !== 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Sends one 8N1 frame, starting just after a tick. Each bit lasts four
    // ticks; the receiver samples the stop bit on its third tick, which is
    // where the model is updated. pop_at_stop raises rx_ready for exactly the
    // clock of that stop sample.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                 input bit pop_at_stop);
        rxd = 1'b0;
        repeat (4) wait_tick();
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (4) wait_tick();
        end
        rxd = stop_bit;
        repeat (2) wait_tick();
        if (pop_at_stop) begin
            repeat (25) @(posedge clk);
            #1 rx_ready = 1'b1;
            @(posedge clk);
            #1 rx_ready = 1'b0;
        end else begin
            wait_tick();
        end
        if (stop_bit) begin
            if (model_q.size() < 4) model_q.push_back(data);
            else exp_ov++;
        end else begin
            exp_fe++;
        end
        checkOutput("busy_after_stop", 32'(rx_busy), 32'd0);
        checkOutput("valid_after_stop", 32'(rx_valid), 32'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            checkOutput("head_after_stop", 32'(rx_data), 32'(model_q[0]));
        end
        wait_tick();
        rxd = 1'b1;
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1 rx_ready = 1'b0;
        checkOutput("drain_valid", 32'(rx_valid), 32'd0);
        checkOutput("drain_model_empty", 32'(model_q.size()), 32'd0);
    endtask

    task automatic check_counts(input string tag);
        checkOutput({tag, "_framing_pulses"}, 32'(fe_cnt), 32'(exp_fe));
        checkOutput({tag, "_overrun_pulses"}, 32'(ov_cnt), 32'(exp_ov));
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        model_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int busy_seen;

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        checkOutput("reset_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset_busy", 32'(rx_busy), 32'd0);
        checkOutput("reset_data", 32'(rx_data), 32'd0);
        checkOutput("reset_framing", 32'(framing_err), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        repeat (2) wait_tick();

        // 1: single good character
        $display("[TB] basic 0xA5");
        applyStimulus(8'hA5, 1'b1, 1'b0);
        check_counts("t1");
        drain();

        // 2: one-tick low glitch is rejected at the start-bit sample
        $display("[TB] start glitch");
        rxd = 1'b0;
        wait_tick();
        checkOutput("glitch_busy_start", 32'(rx_busy), 32'd1);
        rxd = 1'b1;
        repeat (2) wait_tick();
        checkOutput("glitch_busy_end", 32'(rx_busy), 32'd0);
        repeat (4) wait_tick();
        checkOutput("glitch_valid", 32'(rx_valid), 32'd0);
        check_counts("t2");

        // 3: bad stop bit, then a stuck-low line is ignored
        $display("[TB] framing error and stuck-low line");
        applyStimulus(8'h3C, 1'b0, 1'b0);
        rxd = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 80; i++) begin
            wait_tick();
            if (rx_busy) busy_seen++;
        end
        checkOutput("stuck_low_busy", 32'(busy_seen), 32'd0);
        rxd = 1'b1;
        repeat (2) wait_tick();
        checkOutput("t3_valid", 32'(rx_valid), 32'd0);
        check_counts("t3");

        // 4: overrun on the fifth character
        $display("[TB] overrun");
        for (int v = 1; v <= 5; v++) applyStimulus(8'(v), 1'b1, 1'b0);
        check_counts("t4");
        drain();

        // 5: push into a full FIFO coinciding with a pop
        $display("[TB] full FIFO push with pop");
        for (int v = 1; v <= 4; v++) applyStimulus(8'(v * 17), 1'b1, 1'b0);
        applyStimulus(8'h55, 1'b1, 1'b1);
        checkOutput("t5_model_count", 32'(model_q.size()), 32'd4);
        check_counts("t5");
        drain();

        // 6: reset during data bit 4 of 0xFF, line held low afterwards
        $display("[TB] reset mid-frame");
        rxd = 1'b0;
        repeat (4) wait_tick();
        rxd = 1'b1;
        repeat (18) wait_tick();
        checkOutput("t6_busy_before_reset", 32'(rx_busy), 32'd1);
        rxd = 1'b0;
        do_reset();
        checkOutput("t6_busy_after_reset", 32'(rx_busy), 32'd0);
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            wait_tick();
            if (rx_busy) busy_seen++;
        end
        checkOutput("t6_stuck_low_busy", 32'(busy_seen), 32'd0);
        checkOutput("t6_valid", 32'(rx_valid), 32'd0);
        rxd = 1'b1;
        repeat (2) wait_tick();
        applyStimulus(8'h5A, 1'b1, 1'b0);
        checkOutput("t6_head", 32'(rx_data), 32'h5A);
        check_counts("t6");
        drain();

        // Randomized frames with random stop bits, consumer and gaps
        $display("[TB] random frames");
        for (int n = 0; n < 14; n++) begin
            rx_ready = 1'($urandom_range(0, 1));
            applyStimulus(8'($urandom), ($urandom_range(0, 4) != 0), 1'b0);
            repeat ($urandom_range(1, 3)) wait_tick();
        end
        rx_ready = 1'b0;
        check_counts("rand");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
